// File: rtl/hazard_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// hazard_pkg: shared types and parameter checks for the stall controller.
// Rev 1.0
// ----------------------------------------------------------------------
package hazard_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    VEC_BUSY   = 2'd2
  } hz_state_t;

  // A latency must fit the down-counter and insert at least one cycle.
  function automatic bit latency_legal(input int lat, input int cnt_w);
    return (lat >= 1) && (lat < (1 << cnt_w));
  endfunction

endpackage
`default_nettype wire

// File: rtl/stall_down_counter.sv
`default_nettype none
// ----------------------------------------------------------------------
// stall_down_counter: loadable down-counter with zero flag, holds at zero.
// Rev 1.0
// ----------------------------------------------------------------------
module stall_down_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/hazard_stall_controller.sv
`default_nettype none
// ----------------------------------------------------------------------
// hazard_stall_controller: stall/flush sequencing for load-use hazards,
// multi-cycle vector ops and taken branches around EX.  Rev 1.0
// ----------------------------------------------------------------------
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int LOAD_LATENCY = 1,
  parameter int VEC_LATENCY  = 4,
  parameter int CNT_W        = 4,
  parameter int STAT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_decode,
  input  logic [REG_ADDR_W-1:0] rs2_decode,
  input  logic [REG_ADDR_W-1:0] rd_execute,
  input  logic                  mem_read_execute,
  input  logic                  wre_execute,
  input  logic                  wre_vector_execute,
  input  logic                  vector_op_execute,
  input  logic                  branch_taken_execute,
  output logic                  stall_fetch,
  output logic                  stall_decode,
  output logic                  stall_execute,
  output logic                  flush_decode,
  output logic                  flush_execute,
  output logic                  busy,
  output logic [STAT_W-1:0]     stall_cycles
);

  // The RUN cycle that detects the hazard is the first stall cycle, so the
  // counter covers only the remaining cycles spent in the busy states.
  localparam logic [CNT_W-1:0] LOAD_RELOAD = (LOAD_LATENCY > 1) ? CNT_W'(LOAD_LATENCY - 2) : '0;
  localparam logic [CNT_W-1:0] VEC_RELOAD  = (VEC_LATENCY > 2)  ? CNT_W'(VEC_LATENCY - 3)  : '0;

  if (!latency_legal(LOAD_LATENCY, CNT_W)) begin : g_bad_load_latency
    $error("LOAD_LATENCY out of range for CNT_W");
  end
  if (!latency_legal(VEC_LATENCY, CNT_W)) begin : g_bad_vec_latency
    $error("VEC_LATENCY out of range for CNT_W");
  end

  hz_state_t         state_q;
  hz_state_t         state_d;
  logic [STAT_W-1:0] stall_cycles_q;
  logic [STAT_W-1:0] stall_cycles_d;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;
  logic [CNT_W-1:0]  cnt_value;
  logic              load_use;
  logic              sf, sd, se, fd, fe;

  assign load_use = mem_read_execute & (wre_execute | wre_vector_execute) &
                    ((rd_execute == rs1_decode) | (rd_execute == rs2_decode));

  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_value = '0;
    sf        = 1'b0;
    sd        = 1'b0;
    se        = 1'b0;
    fd        = 1'b0;
    fe        = 1'b0;
    unique case (state_q)
      RUN: begin
        if (branch_taken_execute) begin
          fd = 1'b1;
          fe = 1'b1;
        end else if (vector_op_execute && (VEC_LATENCY > 1)) begin
          sf = 1'b1;
          sd = 1'b1;
          se = 1'b1;
          if (VEC_LATENCY > 2) begin
            state_d   = VEC_BUSY;
            cnt_load  = 1'b1;
            cnt_value = VEC_RELOAD;
          end
        end else if (load_use) begin
          sf = 1'b1;
          sd = 1'b1;
          fe = 1'b1;
          if (LOAD_LATENCY > 1) begin
            state_d   = LOAD_STALL;
            cnt_load  = 1'b1;
            cnt_value = LOAD_RELOAD;
          end
        end
      end
      LOAD_STALL: begin
        sf = 1'b1;
        sd = 1'b1;
        fe = 1'b1;
        if (cnt_zero) state_d = RUN;
        else          cnt_dec = 1'b1;
      end
      VEC_BUSY: begin
        sf = 1'b1;
        sd = 1'b1;
        se = 1'b1;
        if (cnt_zero) state_d = RUN;
        else          cnt_dec = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs are forced low for as long as reset is held, even in RUN.
  assign stall_fetch   = rst & sf;
  assign stall_decode  = rst & sd;
  assign stall_execute = rst & se;
  assign flush_decode  = rst & fd;
  assign flush_execute = rst & fe;
  assign busy          = rst & (state_q != RUN);
  assign stall_cycles  = {STAT_W{rst}} & stall_cycles_q;

  assign stall_cycles_d = (stall_fetch && (stall_cycles_q != {STAT_W{1'b1}}))
                        ? stall_cycles_q + STAT_W'(1) : stall_cycles_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= RUN;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  stall_down_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst),
    .load  (cnt_load),
    .value (cnt_value),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------
// tb_hazard_stall_controller: four differently parameterised instances
// checked against a remaining-stall-cycles reference model.  Rev 1.0
// ----------------------------------------------------------------------
module tb_hazard_stall_controller;

  localparam int N = 4;
  localparam logic [N-1:0][4:0] LL = {5'd15, 5'd2, 5'd3, 5'd1};
  localparam logic [N-1:0][4:0] VL = {5'd1,  5'd2, 5'd8, 5'd4};
  localparam logic [N-1:0][4:0] SW = {5'd6,  5'd4, 5'd8, 5'd16};

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       mem_rd, wre, wre_v, vec, br;

  // flags bit order: {stall_fetch, stall_decode, stall_execute, flush_decode, flush_execute, busy}
  wire [N-1:0][5:0]  fl;
  wire [N-1:0][15:0] sc;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    hazard_stall_controller #(
      .LOAD_LATENCY (int'(LL[g])),
      .VEC_LATENCY  (int'(VL[g])),
      .CNT_W        (4),
      .STAT_W       (int'(SW[g]))
    ) u_dut (
      .clk                  (clk),
      .rst                  (rst),
      .rs1_decode           (rs1),
      .rs2_decode           (rs2),
      .rd_execute           (rd),
      .mem_read_execute     (mem_rd),
      .wre_execute          (wre),
      .wre_vector_execute   (wre_v),
      .vector_op_execute    (vec),
      .branch_taken_execute (br),
      .stall_fetch          (fl[g][5]),
      .stall_decode         (fl[g][4]),
      .stall_execute        (fl[g][3]),
      .flush_decode         (fl[g][2]),
      .flush_execute        (fl[g][1]),
      .busy                 (fl[g][0]),
      .stall_cycles         (sc[g][SW[g]-1:0])
    );
    if (SW[g] < 16) begin : g_pad
      assign sc[g][15:SW[g]] = '0;
    end
  end

  // Reference model: number of forced stall cycles still owed, and whether
  // they belong to a vector op; plus the expected statistic value.
  int rem  [N];
  bit kvec [N];
  int stat [N];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [5:0] model_out(input int i);
    bit lu;
    lu = mem_rd && (wre || wre_v) && ((rd == rs1) || (rd == rs2));
    if (!rst)                     return 6'b000000;
    if (rem[i] > 0)               return kvec[i] ? 6'b111001 : 6'b110011;
    if (br)                       return 6'b000110;
    if (vec && (int'(VL[i]) > 1)) return 6'b111000;
    if (lu)                       return 6'b110010;
    return 6'b000000;
  endfunction

  task automatic model_step(input int i, input bit stalled);
    bit lu;
    int max_stat;
    lu = mem_rd && (wre || wre_v) && ((rd == rs1) || (rd == rs2));
    max_stat = (1 << int'(SW[i])) - 1;
    if (!rst) begin
      rem[i]  = 0;
      stat[i] = 0;
    end else begin
      if (stalled && (stat[i] < max_stat)) stat[i] = stat[i] + 1;
      if (rem[i] > 0) begin
        rem[i] = rem[i] - 1;
      end else if (br) begin
        rem[i] = 0;
      end else if (vec && (int'(VL[i]) > 1)) begin
        rem[i]  = int'(VL[i]) - 2;
        kvec[i] = 1'b1;
      end else if (lu) begin
        rem[i]  = int'(LL[i]) - 1;
        kvec[i] = 1'b0;
      end
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                        input logic m, input logic w, input logic wv, input logic v, input logic b);
    rs1 = a1; rs2 = a2; rd = d; mem_rd = m; wre = w; wre_v = wv; vec = v; br = b;
  endtask

  task automatic idle();
    set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock: compare every instance with the model mid-cycle, then advance.
  task automatic cycle(output logic [N-1:0][5:0] fo, output logic [N-1:0][15:0] so);
    logic [5:0] e [N];
    @(negedge clk);
    fo = fl;
    so = sc;
    for (int i = 0; i < N; i++) begin
      e[i] = model_out(i);
      check($sformatf("model dut%0d flags", i), {10'd0, fl[i]}, {10'd0, e[i]});
      check($sformatf("model dut%0d stall_cycles", i), sc[i], rst ? 16'(stat[i]) : 16'd0);
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) model_step(i, e[i][5]);
    #1;
  endtask

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        m, w, wv, v, b;
    logic [5:0]  exp_fl;
    logic [15:0] exp_sc;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                              input logic m, input logic w, input logic wv, input logic v,
                              input logic b, input logic [5:0] ef, input logic [15:0] es);
    vec_t t;
    t.rs1 = a1; t.rs2 = a2; t.rd = d; t.m = m; t.w = w; t.wv = wv; t.v = v; t.b = b;
    t.exp_fl = ef; t.exp_sc = es;
    return t;
  endfunction

  vec_t tbl [15];
  logic [N-1:0][5:0]  fo;
  logic [N-1:0][15:0] so;
  logic [15:0]        sc_start;

  initial begin
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; kvec[i] = 1'b0; stat[i] = 0;
    end
    // Expectations for instance 0 (LOAD_LATENCY=1, VEC_LATENCY=4).
    tbl[0]  = mk(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 6'b000000, 16'd0);
    tbl[1]  = mk(5'd5, 5'd2, 5'd5, 1, 1, 0, 0, 0, 6'b110010, 16'd0);
    tbl[2]  = mk(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 6'b000000, 16'd1);
    tbl[3]  = mk(5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 0, 6'b111000, 16'd1);
    tbl[4]  = mk(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, 6'b111001, 16'd2);
    tbl[5]  = mk(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 6'b111001, 16'd3);
    tbl[6]  = mk(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 6'b000000, 16'd4);
    tbl[7]  = mk(5'd1, 5'd7, 5'd7, 1, 1, 0, 0, 1, 6'b000110, 16'd4);
    tbl[8]  = mk(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 6'b000000, 16'd4);
    tbl[9]  = mk(5'd0, 5'd2, 5'd0, 1, 0, 1, 0, 0, 6'b110010, 16'd4);
    tbl[10] = mk(5'd5, 5'd2, 5'd5, 1, 0, 0, 0, 0, 6'b000000, 16'd5);
    tbl[11] = mk(5'd5, 5'd2, 5'd5, 1, 1, 0, 1, 0, 6'b111000, 16'd5);
    tbl[12] = mk(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 6'b111001, 16'd6);
    tbl[13] = mk(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 6'b111001, 16'd7);
    tbl[14] = mk(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 6'b000000, 16'd8);

    rst = 1'b1;
    idle();
    #1 rst = 1'b0;
    // Reset state, with hazard inputs present to show they are masked.
    set_in(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      cycle(fo, so);
      for (int i = 0; i < N; i++) check($sformatf("reset dut%0d flags", i), {10'd0, fo[i]}, 16'd0);
    end
    rst = 1'b1;

    foreach (tbl[r]) begin
      set_in(tbl[r].rs1, tbl[r].rs2, tbl[r].rd, tbl[r].m, tbl[r].w, tbl[r].wv, tbl[r].v, tbl[r].b);
      cycle(fo, so);
      check($sformatf("table row %0d flags", r), {10'd0, fo[0]}, {10'd0, tbl[r].exp_fl});
      check($sformatf("table row %0d stall_cycles", r), so[0], tbl[r].exp_sc);
    end

    // LOAD_LATENCY=3 on instance 1: three stall cycles, busy in the last two.
    idle();
    for (int k = 0; k < 20; k++) cycle(fo, so);
    set_in(5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(fo, so);
    sc_start = so[1];
    check("load3 cycle1", {10'd0, fo[1]}, 16'b110010);
    idle();
    cycle(fo, so);
    check("load3 cycle2", {10'd0, fo[1]}, 16'b110011);
    cycle(fo, so);
    check("load3 cycle3", {10'd0, fo[1]}, 16'b110011);
    cycle(fo, so);
    check("load3 cycle4", {10'd0, fo[1]}, 16'b000000);
    check("load3 stall_cycles", so[1], sc_start + 16'd3);

    // Reset dropped in the second cycle of a VEC_LATENCY=8 stall on instance 1.
    for (int k = 0; k < 20; k++) cycle(fo, so);
    set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(fo, so);
    check("vec8 start", {10'd0, fo[1]}, 16'b111000);
    idle();
    rst = 1'b0;
    cycle(fo, so);
    for (int i = 0; i < N; i++) check($sformatf("midreset dut%0d flags", i), {10'd0, fo[i]}, 16'd0);
    rst = 1'b1;
    cycle(fo, so);
    check("post-reset flags", {10'd0, fo[1]}, 16'd0);
    check("post-reset stall_cycles", so[1], 16'd0);
    set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(fo, so);
    check("post-reset vec", {10'd0, fo[1]}, 16'b111000);
    idle();
    for (int k = 0; k < 20; k++) cycle(fo, so);

    // Continuous load-use keeps every instance stalling; narrow counters saturate.
    set_in(5'd9, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 300; k++) cycle(fo, so);
    check("saturate dut1", so[1], 16'h00FF);
    check("saturate dut2", so[2], 16'h000F);
    check("saturate dut3", so[3], 16'h003F);
    idle();
    for (int k = 0; k < 20; k++) cycle(fo, so);

    // Random traffic on a small register space so hazards are frequent.
    for (int k = 0; k < 3000; k++) begin
      rs1    = 5'($urandom_range(0, 3));
      rs2    = 5'($urandom_range(0, 3));
      rd     = 5'($urandom_range(0, 3));
      mem_rd = ($urandom % 3) == 0;
      wre    = ($urandom % 2) == 0;
      wre_v  = ($urandom % 4) == 0;
      vec    = ($urandom % 7) == 0;
      br     = ($urandom % 6) == 0;
      rst    = ($urandom % 90) != 0;
      cycle(fo, so);
    end
    rst = 1'b1;
    idle();
    cycle(fo, so);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
